gfx_mem_arbiter: RTL and testbench

GFX_MEM_ARBITER -- requirements
Module: gfx_mem_arbiter

---
 rtl/gfx_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_gfx_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gfx_mem_arbiter
// Purpose  : Single-port graphics RAM arbiter. Client 0 (display fetch) has
//            priority, bounded by a hold counter so that the other clients
//            are not starved. Clients 1..N-1 share the port round-robin.
//            Reads return on a shared broadcast bus tagged by a one-hot strobe.
// Ports    : clk, rst_               clock, synchronous active-high reset
//            cl_addr/cl_wrdata/cl_op per-client request payload (slice i)
//            cl_rts / cl_rtr         per-client request / combinational grant
//            mem_addr/mem_data_out/wben  registered RAM request stage
//            mem_data_in             RAM read data (RD_LAT cycles after addr)
//            bcast_data/bcast_xfc    read-return data and one-hot owner strobe
// Revision : 1.0 - initial release
// ============================================================================
module gfx_mem_arbiter #(
    parameter  int NUM_CLIENTS = 4,
    parameter  int ADDR_W      = 17,
    parameter  int DATA_W      = 32,
    parameter  int RD_LAT      = 1,
    parameter  int MAX_HOLD    = 8,
    localparam int WBEN_W      = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wrdata,
    input  logic [NUM_CLIENTS*WBEN_W-1:0] cl_op,
    input  logic [NUM_CLIENTS-1:0]        cl_rts,
    output logic [NUM_CLIENTS-1:0]        cl_rtr,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_data_out,
    output logic [WBEN_W-1:0]             wben,
    input  logic [DATA_W-1:0]             mem_data_in,
    output logic [DATA_W-1:0]             bcast_data,
    output logic [NUM_CLIENTS-1:0]        bcast_xfc
);

    localparam int                 c_IDX_W    = $clog2(NUM_CLIENTS);
    localparam logic [c_IDX_W:0]   c_NUM_EXT  = (c_IDX_W+1)'(NUM_CLIENTS);
    localparam logic [c_IDX_W:0]   c_NUM_RR   = (c_IDX_W+1)'(NUM_CLIENTS - 1);
    localparam logic [7:0]         c_MAX_HOLD = 8'(MAX_HOLD);

    // Arbiter state
    logic [c_IDX_W-1:0] r_rr_ptr;                 // first client searched (1..N-1)
    logic [7:0]         r_hold;                   // consecutive contested client-0 grants

    // Read tag pipeline: stage s is valid in cycle T+1+s after a grant in T
    logic [RD_LAT:0]    r_tag_vld;
    logic [c_IDX_W-1:0] r_tag_idx [RD_LAT+1];

    logic               w_others;
    logic               w_force_rr;
    logic               w_rr_found;
    logic [c_IDX_W-1:0] w_rr_idx;
    logic [c_IDX_W:0]   w_cand;
    logic               w_gnt_vld;
    logic [c_IDX_W-1:0] w_gnt_idx;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic [WBEN_W-1:0]  w_sel_op;
    logic               w_is_read;

    assign w_others   = |cl_rts[NUM_CLIENTS-1:1];
    // Client 0 has used up its allowance while someone else is waiting
    assign w_force_rr = (r_hold == c_MAX_HOLD) && w_others;

    // Round-robin search over clients 1..N-1 starting at r_rr_ptr. The
    // candidate index is one bit wider so ptr+k can exceed N-1 before the
    // wrap folds it back into 1..N-1 (client 0 is never a candidate).
    always_comb begin : rr_search
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_cand     = '0;
        for (int k = 0; k < NUM_CLIENTS - 1; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (c_IDX_W+1)'(k);
            if (w_cand >= c_NUM_EXT) begin
                w_cand = w_cand - c_NUM_RR;
            end
            if (!w_rr_found && cl_rts[w_cand[c_IDX_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand[c_IDX_W-1:0];
            end
        end
    end

    always_comb begin : grant_sel
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        if (!rst_) begin
            if (cl_rts[0] && !w_force_rr) begin
                w_gnt_vld = 1'b1;
            end else if (w_rr_found) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_rr_idx;
            end
        end
    end

    always_comb begin : rtr_decode
        cl_rtr = '0;
        if (w_gnt_vld) begin
            cl_rtr[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin : req_mux
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_op   = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (w_gnt_idx == c_IDX_W'(i)) begin
                w_sel_addr = cl_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = cl_wrdata[i*DATA_W +: DATA_W];
                w_sel_op   = cl_op[i*WBEN_W +: WBEN_W];
            end
        end
    end

    assign w_is_read = (w_sel_op == '0);

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_rr_ptr     <= c_IDX_W'(1);
            r_hold       <= '0;
            mem_addr     <= '0;
            mem_data_out <= '0;
            wben         <= '0;
            r_tag_vld    <= '0;
            for (int s = 0; s <= RD_LAT; s++) begin
                r_tag_idx[s] <= '0;
            end
            bcast_data   <= '0;
            bcast_xfc    <= '0;
        end else begin
            // Only contested client-0 grants count; anything else clears it
            if (w_gnt_vld && (w_gnt_idx == '0) && w_others) begin
                r_hold <= r_hold + 8'd1;
            end else begin
                r_hold <= '0;
            end

            if (w_gnt_vld && (w_gnt_idx != '0)) begin
                r_rr_ptr <= (w_gnt_idx == c_IDX_W'(NUM_CLIENTS - 1)) ?
                            c_IDX_W'(1) : w_gnt_idx + c_IDX_W'(1);
            end

            // Address and data hold when idle so the RAM sees no spurious change
            if (w_gnt_vld) begin
                mem_addr     <= w_sel_addr;
                mem_data_out <= w_sel_data;
                wben         <= w_sel_op;
            end else begin
                wben         <= '0;
            end

            r_tag_vld[0] <= w_gnt_vld && w_is_read;
            r_tag_idx[0] <= w_gnt_idx;
            for (int s = 1; s <= RD_LAT; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_idx[s] <= r_tag_idx[s-1];
            end

            // Last tag stage lines up with the RAM data for that read
            if (r_tag_vld[RD_LAT]) begin
                bcast_xfc  <= NUM_CLIENTS'(1) << r_tag_idx[RD_LAT];
                bcast_data <= mem_data_in;
            end else begin
                bcast_xfc  <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gfx_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gfx_mem_arbiter
// Purpose  : Self-checking bench for gfx_mem_arbiter. Two instances share the
//            client stimulus, one with RD_LAT=1 and one with RD_LAT=2, each
//            behind its own RAM model. Grants and request-stage outputs are
//            checked per cycle; read returns go through a scoreboard.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_gfx_mem_arbiter;

    typedef struct {
        int          client;
        logic [31:0] data;
        int          due;
    } sb_t;

    typedef struct packed {
        logic [3:0] rts;
        logic [3:0] exp_rtr;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_;
    logic [67:0]  cl_addr;
    logic [127:0] cl_wrdata;
    logic [15:0]  cl_op;
    logic [3:0]   cl_rts;

    logic [3:0]  rtr1, rtr2, bx1, bx2, wben1, wben2;
    logic [16:0] maddr1, maddr2;
    logic [31:0] mdo1, mdo2, mdi1, mdi2, bd1, bd2;
    logic [31:0] rd1_q, rd2_q, rd2_qq;

    logic [16:0] addr_cfg [4];
    logic [31:0] data_cfg [4];
    logic [3:0]  op_cfg   [4];

    logic [16:0] exp_addr  = '0;
    logic [31:0] exp_wdata = '0;
    logic [3:0]  exp_wben  = '0;
    logic [31:0] bd_exp [2];

    sb_t  sbq [2][$];
    vec_t tbl [13];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        cl_addr   = '0;
        cl_wrdata = '0;
        cl_op     = '0;
        for (int i = 0; i < 4; i++) begin
            cl_addr[i*17 +: 17]  = addr_cfg[i];
            cl_wrdata[i*32 +: 32] = data_cfg[i];
            cl_op[i*4 +: 4]      = op_cfg[i];
        end
    end

    function automatic logic [31:0] ram_word(input logic [16:0] a);
        if (a == 17'h00010) return 32'hDEADBEEF;
        return {8'hA0 ^ a[7:0], a[7:0], ~a[7:0], 8'h5C};
    endfunction

    // RAM models: data appears RD_LAT cycles after the address cycle
    always @(posedge clk) rd1_q <= ram_word(maddr1);
    always @(posedge clk) begin
        rd2_q  <= ram_word(maddr2);
        rd2_qq <= rd2_q;
    end
    assign mdi1 = rd1_q;
    assign mdi2 = rd2_qq;

    gfx_mem_arbiter #(.NUM_CLIENTS(4), .ADDR_W(17), .DATA_W(32), .RD_LAT(1), .MAX_HOLD(8)) dut1 (
        .clk(clk), .rst_(rst_), .cl_addr(cl_addr), .cl_wrdata(cl_wrdata), .cl_op(cl_op),
        .cl_rts(cl_rts), .cl_rtr(rtr1), .mem_addr(maddr1), .mem_data_out(mdo1), .wben(wben1),
        .mem_data_in(mdi1), .bcast_data(bd1), .bcast_xfc(bx1)
    );

    gfx_mem_arbiter #(.NUM_CLIENTS(4), .ADDR_W(17), .DATA_W(32), .RD_LAT(2), .MAX_HOLD(8)) dut2 (
        .clk(clk), .rst_(rst_), .cl_addr(cl_addr), .cl_wrdata(cl_wrdata), .cl_op(cl_op),
        .cl_rts(cl_rts), .cl_rtr(rtr2), .mem_addr(maddr2), .mem_data_out(mdo2), .wben(wben2),
        .mem_data_in(mdi2), .bcast_data(bd2), .bcast_xfc(bx2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_cfg(input int i, input logic [16:0] a, input logic [31:0] d, input logic [3:0] op);
        addr_cfg[i] = a;
        data_cfg[i] = d;
        op_cfg[i]   = op;
    endtask

    task automatic check_mem();
        chk("mem_addr", 64'(maddr1), 64'(exp_addr));
        chk("mem_data_out", 64'(mdo1), 64'(exp_wdata));
        chk("wben", 64'(wben1), 64'(exp_wben));
        chk("wben_lat2", 64'(wben2), 64'(exp_wben));
        chk("mem_addr_lat2", 64'(maddr2), 64'(exp_addr));
    endtask

    // One arbitration cycle; called at posedge+1, returns at next posedge+1
    task automatic cyc_step(input logic [3:0] rts, input logic [3:0] exp_rtr);
        int  idx;
        sb_t e;
        cl_rts = rts;
        @(negedge clk);
        check_mem();
        chk("cl_rtr", 64'(rtr1), 64'(exp_rtr));
        chk("cl_rtr_lat2", 64'(rtr2), 64'(exp_rtr));
        idx = -1;
        for (int i = 0; i < 4; i++) begin
            if (exp_rtr[i]) idx = i;
        end
        if (idx >= 0) begin
            exp_addr  = addr_cfg[idx];
            exp_wdata = data_cfg[idx];
            exp_wben  = op_cfg[idx];
            if (op_cfg[idx] == 4'b0000) begin
                e.client = idx;
                e.data   = ram_word(addr_cfg[idx]);
                e.due    = cyc + 3;
                sbq[0].push_back(e);
                e.due    = cyc + 4;
                sbq[1].push_back(e);
            end
        end else begin
            exp_wben = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_   = 1'b1;
        cl_rts = 4'hF;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_mem();
            chk("cl_rtr_in_reset", 64'(rtr1), 64'(0));
            chk("cl_rtr_in_reset_lat2", 64'(rtr2), 64'(0));
            exp_addr  = '0;
            exp_wdata = '0;
            exp_wben  = '0;
            @(posedge clk);
            #1;
            sbq[0].delete();
            sbq[1].delete();
        end
        rst_   = 1'b0;
        cl_rts = 4'h0;
    endtask

    task automatic mon_one(input int k, input logic [3:0] xfc, input logic [31:0] data, input logic after_rst);
        sb_t e;
        if (after_rst) begin
            chk($sformatf("bcast_xfc_reset[lat%0d]", k+1), 64'(xfc), 64'(0));
            chk($sformatf("bcast_data_reset[lat%0d]", k+1), 64'(data), 64'(0));
            bd_exp[k] = '0;
        end else if (xfc != 4'b0000 || (sbq[k].size() > 0 && sbq[k][0].due == cyc)) begin
            if (sbq[k].size() == 0) begin
                chk($sformatf("bcast_xfc_unexpected[lat%0d]", k+1), 64'(xfc), 64'(0));
            end else begin
                e = sbq[k].pop_front();
                chk($sformatf("bcast_xfc[lat%0d]", k+1), 64'(xfc), 64'(4'b0001 << e.client));
                chk($sformatf("bcast_data[lat%0d]", k+1), 64'(data), 64'(e.data));
                chk($sformatf("bcast_cycle[lat%0d]", k+1), 64'(cyc), 64'(e.due));
                bd_exp[k] = e.data;
            end
        end else begin
            chk($sformatf("bcast_data_hold[lat%0d]", k+1), 64'(data), 64'(bd_exp[k]));
        end
    endtask

    // Read-return monitor; outputs seen here reflect the previous edge
    initial begin
        logic prev_rst;
        prev_rst = 1'b1;
        forever begin
            @(negedge clk);
            mon_one(0, bx1, bd1, prev_rst);
            mon_one(1, bx2, bd2, prev_rst);
            prev_rst = rst_;
        end
    end

    initial begin
        // Arbitration sequence; assumes rr pointer at client 1 and hold at 0
        tbl[0]  = '{4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 4'b0001};
        tbl[2]  = '{4'b0110, 4'b0010};
        tbl[3]  = '{4'b0110, 4'b0100};
        tbl[4]  = '{4'b1011, 4'b0001};
        tbl[5]  = '{4'b1010, 4'b1000};
        tbl[6]  = '{4'b1110, 4'b0010};
        tbl[7]  = '{4'b1010, 4'b1000};
        tbl[8]  = '{4'b0100, 4'b0100};
        tbl[9]  = '{4'b0011, 4'b0001};
        tbl[10] = '{4'b0011, 4'b0001};
        tbl[11] = '{4'b0010, 4'b0010};
        tbl[12] = '{4'b0000, 4'b0000};

        rst_   = 1'b1;
        cl_rts = '0;
        set_cfg(0, 17'h00030, 32'h0, 4'b0000);
        set_cfg(1, 17'h00021, 32'h0, 4'b0000);
        set_cfg(2, 17'h00022, 32'h0, 4'b0000);
        set_cfg(3, 17'h00023, 32'h0, 4'b0000);
        do_reset(3);

        // Round robin among 1..3, first transfer right after reset
        for (int r = 0; r < 2; r++) begin
            cyc_step(4'b1110, 4'b0010);
            cyc_step(4'b1110, 4'b0100);
            cyc_step(4'b1110, 4'b1000);
        end
        for (int i = 0; i < 4; i++) cyc_step(4'b0000, 4'b0000);

        // Single read returning 0xDEADBEEF
        set_cfg(2, 17'h00010, 32'h0, 4'b0000);
        cyc_step(4'b0100, 4'b0100);
        for (int i = 0; i < 5; i++) cyc_step(4'b0000, 4'b0000);

        // Partial write, no read return
        set_cfg(1, 17'h00005, 32'h12345678, 4'b0011);
        cyc_step(4'b0010, 4'b0010);
        for (int i = 0; i < 4; i++) cyc_step(4'b0000, 4'b0000);

        // Client 0 vs client 3: eight client-0 grants then one client-3 grant
        set_cfg(3, 17'h00040, 32'hCAFEF00D, 4'b1111);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) cyc_step(4'b1001, 4'b0001);
            cyc_step(4'b1001, 4'b1000);
        end
        cyc_step(4'b0000, 4'b0000);

        // Mixed priority / round-robin vector table
        set_cfg(1, 17'h00031, 32'h0, 4'b0000);
        set_cfg(2, 17'h00042, 32'hA5A5A5A5, 4'b0101);
        set_cfg(3, 17'h00033, 32'h0, 4'b0000);
        for (int i = 0; i < 13; i++) cyc_step(tbl[i].rts, tbl[i].exp_rtr);
        for (int i = 0; i < 4; i++) cyc_step(4'b0000, 4'b0000);

        // Lone client 0 never advances the hold counter
        for (int i = 0; i < 12; i++) cyc_step(4'b0001, 4'b0001);
        for (int i = 0; i < 8; i++) cyc_step(4'b1001, 4'b0001);
        cyc_step(4'b1001, 4'b1000);
        for (int i = 0; i < 5; i++) cyc_step(4'b0000, 4'b0000);

        // Back-to-back reads from clients 0 then 1
        cyc_step(4'b0011, 4'b0001);
        cyc_step(4'b0010, 4'b0010);
        for (int i = 0; i < 6; i++) cyc_step(4'b0000, 4'b0000);

        // Reset while reads are in flight: no returns may appear
        set_cfg(1, 17'h00021, 32'h0, 4'b0000);
        set_cfg(2, 17'h00022, 32'h0, 4'b0000);
        set_cfg(3, 17'h00023, 32'h0, 4'b0000);
        cyc_step(4'b0010, 4'b0010);
        cyc_step(4'b0100, 4'b0100);
        do_reset(1);
        for (int i = 0; i < 6; i++) cyc_step(4'b0000, 4'b0000);

        chk("sb_drain_lat1", 64'(sbq[0].size()), 64'(0));
        chk("sb_drain_lat2", 64'(sbq[1].size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
